// File: rtl/dw02_sum_unpack_pkg.sv
// dw02_sum_unpack_pkg
//   Shared definitions for the dw02_sum_unpack slice: FSM state encoding and
//   the slice-index width helper used by the interface, top and mux.
package dw02_sum_unpack_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Index width: clog2(n), but never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dw02_sum_unpack_if.sv
// dw02_sum_unpack_if
//   Bus bundle for dw02_sum_unpack.
//   Input side : in_valid/in_ready handshake carrying the packed INPUT vector.
//   Output side: out_valid/out_ready handshake carrying out_data/out_idx/out_last.
//   Result     : SUM with its one-cycle sum_valid strobe.
//   Modports   : master = traffic source/sink (bench or parent), slave = the block.
interface dw02_sum_unpack_if
  import dw02_sum_unpack_pkg::*;
#(
  parameter int unsigned num_inputs  = 4,
  parameter int unsigned input_width = 32
);
  localparam int unsigned IDXW = idx_width(num_inputs);

  logic                              in_valid;
  logic                              in_ready;
  logic [input_width*num_inputs-1:0] INPUT;
  logic                              out_valid;
  logic                              out_ready;
  logic [input_width-1:0]            out_data;
  logic [IDXW-1:0]                   out_idx;
  logic                              out_last;
  logic [input_width-1:0]            SUM;
  logic                              sum_valid;

  modport master (
    output in_valid, INPUT, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, SUM, sum_valid
  );

  modport slave (
    input  in_valid, INPUT, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, SUM, sum_valid
  );

endinterface

// File: rtl/dw02_sum_slice_mux.sv
// dw02_sum_slice_mux
//   Combinational selector of one input_width slice from the packed shadow
//   register.
//   shadow : packed operands, slice k at bits [k*input_width +: input_width]
//   idx    : slice to select (out-of-range values yield zero)
//   slice  : selected operand
module dw02_sum_slice_mux #(
  parameter int unsigned num_inputs  = 4,
  parameter int unsigned input_width = 32,
  parameter int unsigned IDXW        = 2
) (
  input  logic [input_width*num_inputs-1:0] shadow,
  input  logic [IDXW-1:0]                   idx,
  output logic [input_width-1:0]            slice
);

  always_comb begin
    slice = '0;
    for (int unsigned k = 0; k < num_inputs; k++) begin
      if (idx == IDXW'(k)) begin
        slice = shadow[k*input_width +: input_width];
      end
    end
  end

endmodule

// File: rtl/dw02_sum_unpack.sv
// dw02_sum_unpack
//   Accepts a packed vector of num_inputs operands, streams the operands out
//   one beat per transfer (slice 0 first) and publishes their modulo
//   2^input_width total on SUM once the last beat has been taken.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   io  : dw02_sum_unpack_if.slave (input handshake, output beat stream, SUM)
module dw02_sum_unpack
  import dw02_sum_unpack_pkg::*;
#(
  parameter int unsigned num_inputs  = 4,
  parameter int unsigned input_width = 32
) (
  input logic               clk,
  input logic               rst,
  dw02_sum_unpack_if.slave  io
);

  localparam int unsigned     IDXW     = idx_width(num_inputs);
  localparam int unsigned     VW       = input_width * num_inputs;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(num_inputs - 1);

  state_e                 state_q, state_d;
  logic [VW-1:0]          shadow_q, shadow_d;
  logic [IDXW-1:0]        idx_q, idx_d;
  logic [input_width-1:0] acc_q, acc_d;
  logic [input_width-1:0] sum_q, sum_d;
  logic                   sum_valid_q, sum_valid_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic [input_width-1:0] slice;

  dw02_sum_slice_mux #(
    .num_inputs (num_inputs),
    .input_width(input_width),
    .IDXW       (IDXW)
  ) u_slice_mux (
    .shadow(shadow_q),
    .idx   (idx_q),
    .slice (slice)
  );

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    sum_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          shadow_d = io.INPUT;
          idx_d    = '0;
          acc_d    = '0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (io.out_ready) begin
          acc_d = acc_q + slice;
          if (idx_q == LAST_IDX) begin
            sum_d       = acc_q + slice;
            sum_valid_d = 1'b1;
            state_d     = IDLE;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
    endcase

    // Beat flags are registered, so they are derived from the next state/index.
    out_valid_d = (state_d == STREAM);
    out_last_d  = (state_d == STREAM) && (idx_d == LAST_IDX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_valid_q ? slice : '0;
  assign io.out_idx   = idx_q;
  assign io.out_last  = out_last_q;
  assign io.SUM       = sum_q;
  assign io.sum_valid = sum_valid_q;

endmodule

// File: tb/tb_dw02_sum_unpack.sv
// tb_dw02_sum_unpack
//   Scoreboard bench: expected beats and sums are queued when a vector is
//   offered and retired as the DUT presents them. A second instance covers the
//   single-operand configuration.
module tb_dw02_sum_unpack;

  localparam int unsigned N = 4;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dw02_sum_unpack_if #(.num_inputs(N), .input_width(W)) ifa ();
  dw02_sum_unpack_if #(.num_inputs(1), .input_width(W)) ifb ();

  dw02_sum_unpack #(.num_inputs(N), .input_width(W)) u_dut (
    .clk(clk),
    .rst(rst),
    .io (ifa)
  );

  dw02_sum_unpack #(.num_inputs(1), .input_width(W)) u_dut1 (
    .clk(clk),
    .rst(rst),
    .io (ifb)
  );

  typedef struct {
    logic [W-1:0] data;
    logic [1:0]   idx;
    logic         last;
  } beat_t;

  beat_t        beat_q[$];
  logic [W-1:0] sum_q[$];
  logic [W-1:0] sum_hold = '0;
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N*W-1:0] rand_vec();
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = $urandom();
    return v;
  endfunction

  task automatic push_vec(input logic [N*W-1:0] vec);
    logic [W-1:0] s;
    beat_t        b;
    s = '0;
    for (int k = 0; k < N; k++) begin
      b.data = vec[k*W +: W];
      b.idx  = 2'(k);
      b.last = (k == N - 1);
      beat_q.push_back(b);
      s = s + b.data;
    end
    sum_q.push_back(s);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (ifa.out_valid === 1'b1) begin
        if (beat_q.size() == 0) begin
          check_eq("beat_unexpected", ifa.out_valid, 64'd0);
        end else begin
          check_eq("out_data", ifa.out_data, beat_q[0].data);
          check_eq("out_idx", ifa.out_idx, beat_q[0].idx);
          check_eq("out_last", ifa.out_last, beat_q[0].last);
          if (ifa.out_ready === 1'b1) void'(beat_q.pop_front());
        end
      end
      if (ifa.sum_valid === 1'b1) begin
        if (sum_q.size() == 0) begin
          check_eq("sum_valid_unexpected", ifa.sum_valid, 64'd0);
        end else begin
          sum_hold = sum_q.pop_front();
          check_eq("SUM", ifa.SUM, sum_hold);
        end
      end else begin
        check_eq("SUM_hold", ifa.SUM, sum_hold);
      end
    end
  end

  // Called at posedge+1 with the DUT idle or about to be idle.
  task automatic send(input logic [N*W-1:0] vec);
    int unsigned t = 0;
    while (ifa.in_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq("accept_wait", ifa.in_ready, 64'd1);
    ifa.INPUT    = vec;
    ifa.in_valid = 1'b1;
    push_vec(vec);
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    ifa.INPUT    = rand_vec();
    check_eq("first_beat_latency", ifa.out_valid, 64'd1);
    check_eq("in_ready_stream", ifa.in_ready, 64'd0);
  endtask

  // mode 0: out_ready=1; mode 1: 1,0,0,1 repeating; otherwise random.
  task automatic drain(input int mode);
    int unsigned c = 0;
    while ((beat_q.size() != 0 || sum_q.size() != 0) && c < 200) begin
      case (mode)
        0:       ifa.out_ready = 1'b1;
        1:       ifa.out_ready = ((c % 4) == 0) || ((c % 4) == 3);
        default: ifa.out_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk); #1;
      c++;
    end
    check_eq("drain_done", 64'(beat_q.size() + sum_q.size()), 64'd0);
    ifa.out_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*W-1:0] vec;

    rst           = 1'b1;
    ifa.in_valid  = 1'b0;
    ifa.INPUT     = '0;
    ifa.out_ready = 1'b0;
    ifb.in_valid  = 1'b0;
    ifb.INPUT     = '0;
    ifb.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    check_eq("rst_out_valid", ifa.out_valid, 64'd0);
    check_eq("rst_out_data", ifa.out_data, 64'd0);
    check_eq("rst_out_idx", ifa.out_idx, 64'd0);
    check_eq("rst_out_last", ifa.out_last, 64'd0);
    check_eq("rst_SUM", ifa.SUM, 64'd0);
    check_eq("rst_sum_valid", ifa.sum_valid, 64'd0);
    check_eq("rst1_out_valid", ifb.out_valid, 64'd0);
    check_eq("rst1_SUM", ifb.SUM, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_in_ready", ifa.in_ready, 64'd1);
    check_eq("rst1_in_ready", ifb.in_ready, 64'd1);

    // out_ready in IDLE must not start anything.
    ifa.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("idle_out_ready_valid", ifa.out_valid, 64'd0);
    check_eq("idle_out_ready_idx", ifa.out_idx, 64'd0);

    // Basic vector {1,2,3,4}.
    send({32'd4, 32'd3, 32'd2, 32'd1});
    drain(0);
    check_eq("sum_1234", ifa.SUM, 64'd10);

    // Carry out of the top bit is discarded.
    send({32'd0, 32'd0, 32'd2, 32'hFFFF_FFFF});
    drain(0);
    check_eq("sum_carry", ifa.SUM, 64'h1);

    // Stall pattern 1,0,0,1.
    send({32'd40, 32'd30, 32'd20, 32'd10});
    drain(1);
    check_eq("sum_stall", ifa.SUM, 64'd100);

    // Random vectors with random backpressure.
    for (int r = 0; r < 4; r++) begin
      send(rand_vec());
      drain(2);
    end

    // Reset after the second beat aborts the vector.
    ifa.out_ready = 1'b1;
    send({32'd9, 32'd9, 32'd9, 32'd9});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("abort_out_valid", ifa.out_valid, 64'd0);
    check_eq("abort_out_data", ifa.out_data, 64'd0);
    check_eq("abort_out_idx", ifa.out_idx, 64'd0);
    check_eq("abort_out_last", ifa.out_last, 64'd0);
    check_eq("abort_SUM", ifa.SUM, 64'd0);
    check_eq("abort_sum_valid", ifa.sum_valid, 64'd0);
    beat_q.delete();
    sum_q.delete();
    sum_hold = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("abort_in_ready", ifa.in_ready, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    send({32'd5, 32'd5, 32'd5, 32'd5});
    drain(0);
    check_eq("sum_after_abort", ifa.SUM, 64'd20);

    // in_valid held high: INPUT during STREAM is ignored, vectors one IDLE cycle apart.
    ifa.out_ready = 1'b1;
    ifa.in_valid  = 1'b1;
    for (int v = 0; v < 3; v++) begin
      vec       = rand_vec();
      ifa.INPUT = vec;
      push_vec(vec);
      @(posedge clk); #1;
      check_eq("b2b_accepted", ifa.out_valid, 64'd1);
      for (int c = 0; c < N; c++) begin
        ifa.INPUT = rand_vec();
        @(posedge clk); #1;
        check_eq("b2b_in_ready", ifa.in_ready, (c == N - 1) ? 64'd1 : 64'd0);
      end
    end
    ifa.in_valid = 1'b0;
    drain(0);

    // Single-operand instance.
    ifb.out_ready = 1'b0;
    ifb.INPUT     = 32'h0000_ABCD;
    ifb.in_valid  = 1'b1;
    @(posedge clk); #1;
    ifb.in_valid = 1'b0;
    ifb.INPUT    = 32'h1234_5678;
    check_eq("n1_out_valid", ifb.out_valid, 64'd1);
    check_eq("n1_out_last", ifb.out_last, 64'd1);
    check_eq("n1_out_idx", ifb.out_idx, 64'd0);
    check_eq("n1_out_data", ifb.out_data, 64'h0000_ABCD);
    check_eq("n1_in_ready", ifb.in_ready, 64'd0);
    @(posedge clk); #1;
    check_eq("n1_stall_data", ifb.out_data, 64'h0000_ABCD);
    check_eq("n1_stall_sum_valid", ifb.sum_valid, 64'd0);
    check_eq("n1_stall_SUM", ifb.SUM, 64'd0);
    ifb.out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("n1_sum_valid", ifb.sum_valid, 64'd1);
    check_eq("n1_SUM", ifb.SUM, 64'h0000_ABCD);
    check_eq("n1_done_out_valid", ifb.out_valid, 64'd0);
    check_eq("n1_done_in_ready", ifb.in_ready, 64'd1);
    @(posedge clk); #1;
    check_eq("n1_pulse_end", ifb.sum_valid, 64'd0);
    check_eq("n1_SUM_hold", ifb.SUM, 64'h0000_ABCD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
